// File: rtl/ram_pkg.sv
// Shared RAM geometry and March C- BIST types.
//   DATA_WIDTH / ADDR_WIDTH / DEPTH : default RAM geometry
//   march_elem_e                    : March C- element index (M0..M5)
//   PAT0 / PAT1                     : background patterns (all zeros / all ones)
package ram_pkg;

  localparam int unsigned DATA_WIDTH = 8;
  localparam int unsigned ADDR_WIDTH = 4;
  localparam int unsigned DEPTH      = 16;

  typedef enum logic [2:0] {
    ELEM_M0 = 3'd0,
    ELEM_M1 = 3'd1,
    ELEM_M2 = 3'd2,
    ELEM_M3 = 3'd3,
    ELEM_M4 = 3'd4,
    ELEM_M5 = 3'd5
  } march_elem_e;

  localparam logic [DATA_WIDTH-1:0] PAT0 = '0;
  localparam logic [DATA_WIDTH-1:0] PAT1 = '1;

endpackage

// File: rtl/ram_bist_addr_gen.sv
// Up/down address counter for the BIST walk.
//   clk, rst  : clock, async active-high reset
//   load_lo   : load address 0 (start of an ascending element)
//   load_hi   : load address DEPTH-1 (start of a descending element)
//   step      : advance one address in the direction given by up
//   up        : 1 = ascending, 0 = descending
//   addr      : current address (registered)
//   last      : registered flag, addr is the final address of the current walk
module ram_bist_addr_gen #(
  parameter int unsigned ADDR_WIDTH = ram_pkg::ADDR_WIDTH,
  parameter int unsigned DEPTH      = ram_pkg::DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_lo,
  input  logic                  load_hi,
  input  logic                  step,
  input  logic                  up,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  last
);

  localparam logic [ADDR_WIDTH-1:0] TOP = ADDR_WIDTH'(DEPTH - 1);

  logic [ADDR_WIDTH-1:0] addr_nxt;

  // Modulo-DEPTH next address; never leaves 0..DEPTH-1.
  always_comb begin
    addr_nxt = addr;
    if (load_lo) begin
      addr_nxt = '0;
    end else if (load_hi) begin
      addr_nxt = TOP;
    end else if (step) begin
      if (up) addr_nxt = (addr == TOP) ? '0 : addr + ADDR_WIDTH'(1);
      else    addr_nxt = (addr == '0) ? TOP : addr - ADDR_WIDTH'(1);
    end
  end

  // A fresh walk (DEPTH >= 2) never starts on its last address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr <= '0;
      last <= 1'b0;
    end else begin
      addr <= addr_nxt;
      if (load_lo || load_hi) last <= 1'b0;
      else if (step)          last <= up ? (addr_nxt == TOP) : (addr_nxt == '0);
    end
  end

endmodule

// File: rtl/ram_bist_ctrl.sv
// March C- BIST controller driving the single RAM port.
//   clk, rst    : clock, async active-high reset
//   start       : one-cycle pulse, accepted only when not busy
//   ram_*       : RAM port (read data returns one cycle after ram_rd_en)
//   busy / done : run in progress / run finished (held until next start)
//   pass        : no mismatches in the finished run
//   fail_addr, fail_elem : location of the first mismatch
//   err_cnt     : saturating mismatch count
module ram_bist_ctrl #(
  parameter int unsigned DATA_WIDTH = ram_pkg::DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = ram_pkg::ADDR_WIDTH,
  parameter int unsigned DEPTH      = ram_pkg::DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_wr_en,
  output logic                  ram_rd_en,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [2:0]            fail_elem,
  output logic [15:0]           err_cnt
);
  import ram_pkg::*;

  localparam int unsigned           CNT_WIDTH = 16;
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX   = '1;
  localparam logic [DATA_WIDTH-1:0] P0        = {DATA_WIDTH{PAT0[0]}};
  localparam logic [DATA_WIDTH-1:0] P1        = {DATA_WIDTH{PAT1[0]}};

  typedef enum logic [3:0] {
    IDLE, M0, M1_RD, M1_WR, M2_RD, M2_WR, M3_RD, M3_WR,
    M4_RD, M4_WR, M5, M5_FLUSH, DONE
  } state_t;

  state_t                state, state_nxt;
  logic                  start_ok, load_lo, load_hi, step, up, last;
  logic                  pend_vld, mismatch;
  logic [ADDR_WIDTH-1:0] pend_addr;
  logic [DATA_WIDTH-1:0] pend_exp;
  march_elem_e           pend_elem;
  logic [CNT_WIDTH-1:0]  err_cnt_nxt;

  function automatic logic is_rd(state_t s);
    return s inside {M1_RD, M2_RD, M3_RD, M4_RD, M5};
  endfunction

  function automatic logic is_wr(state_t s);
    return s inside {M0, M1_WR, M2_WR, M3_WR, M4_WR};
  endfunction

  function automatic march_elem_e elem_of(state_t s);
    case (s)
      M1_RD, M1_WR: return ELEM_M1;
      M2_RD, M2_WR: return ELEM_M2;
      M3_RD, M3_WR: return ELEM_M3;
      M4_RD, M4_WR: return ELEM_M4;
      M5:           return ELEM_M5;
      default:      return ELEM_M0;
    endcase
  endfunction

  ram_bist_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_addr_gen (
    .clk     (clk),
    .rst     (rst),
    .load_lo (load_lo),
    .load_hi (load_hi),
    .step    (step),
    .up      (up),
    .addr    (ram_addr),
    .last    (last)
  );

  assign start_ok = start && (state == IDLE || state == DONE);
  assign mismatch = pend_vld && (ram_rdata != pend_exp);

  // Next state and address-counter control.
  always_comb begin
    state_nxt = state;
    load_lo   = 1'b0;
    load_hi   = 1'b0;
    step      = 1'b0;
    up        = 1'b1;
    case (state)
      IDLE, DONE: if (start_ok) begin state_nxt = M0; load_lo = 1'b1; end
      M0:       if (last) begin state_nxt = M1_RD; load_lo = 1'b1; end else step = 1'b1;
      M1_RD:    state_nxt = M1_WR;
      M1_WR:    if (last) begin state_nxt = M2_RD; load_lo = 1'b1; end
                else begin state_nxt = M1_RD; step = 1'b1; end
      M2_RD:    state_nxt = M2_WR;
      M2_WR:    if (last) begin state_nxt = M3_RD; load_hi = 1'b1; end
                else begin state_nxt = M2_RD; step = 1'b1; end
      M3_RD:    state_nxt = M3_WR;
      M3_WR:    begin
                  up = 1'b0;
                  if (last) begin state_nxt = M4_RD; load_hi = 1'b1; end
                  else begin state_nxt = M3_RD; step = 1'b1; end
                end
      M4_RD:    state_nxt = M4_WR;
      M4_WR:    begin
                  up = 1'b0;
                  if (last) begin state_nxt = M5; load_lo = 1'b1; end
                  else begin state_nxt = M4_RD; step = 1'b1; end
                end
      M5:       if (last) state_nxt = M5_FLUSH; else step = 1'b1;
      M5_FLUSH: state_nxt = DONE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Saturating mismatch counter, cleared by an accepted start.
  always_comb begin
    err_cnt_nxt = err_cnt;
    if (start_ok)                          err_cnt_nxt = '0;
    else if (mismatch && err_cnt != CNT_MAX) err_cnt_nxt = err_cnt + CNT_WIDTH'(1);
  end

  // State plus registered outputs; read context is kept one cycle for the compare.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ram_wr_en <= 1'b0;
      ram_rd_en <= 1'b0;
      ram_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_addr <= '0;
      fail_elem <= '0;
      err_cnt   <= '0;
      pend_vld  <= 1'b0;
      pend_addr <= '0;
      pend_exp  <= '0;
      pend_elem <= ELEM_M0;
    end else begin
      state     <= state_nxt;
      ram_wr_en <= is_wr(state_nxt);
      ram_rd_en <= is_rd(state_nxt);
      ram_wdata <= (state_nxt == M1_WR || state_nxt == M3_WR) ? P1 : P0;
      busy      <= !(state_nxt == IDLE || state_nxt == DONE);
      done      <= (state_nxt == DONE);
      pend_vld  <= is_rd(state);
      pend_addr <= ram_addr;
      pend_exp  <= (state == M2_RD || state == M4_RD) ? P1 : P0;
      pend_elem <= elem_of(state);
      err_cnt   <= err_cnt_nxt;
      if (start_ok) begin
        pass      <= 1'b0;
        fail_addr <= '0;
        fail_elem <= '0;
      end else begin
        if (mismatch && err_cnt == '0) begin
          fail_addr <= pend_addr;
          fail_elem <= 3'(pend_elem);
        end
        if (state == M5_FLUSH) pass <= (err_cnt_nxt == '0);
      end
    end
  end

endmodule
